// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending controller.
//   N      : number of request lines, fixed to match the 8-to-3 priority encoder
//   IDX_W  : width of an encoded request index
//   state_e: handshake FSM states (IDLE, REQ, SVC)
package irq_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser for an asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : synchronised output (last stage)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the raw input in at bit 0; the top bit is the settled copy.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt request front end feeding an 8-to-3 priority encoder.
// Synchronises the raw request lines, latches them as edge- or level-
// triggered pending bits, masks them onto req and runs the irq/ack/eoi
// handshake with the consumer.
//   clk, rst_n : system clock, asynchronous active-low reset
//   irq_in     : raw asynchronous request lines
//   mask       : per-line enable (1 = enabled)
//   edge_mode  : 1 = rising-edge latched, 0 = level-sensitive
//   ack/ack_id : acknowledge pulse and the encoder index being served
//   eoi        : end-of-service pulse
//   req        : pending & mask, to the encoder
//   irq        : interrupt request to the consumer
//   in_service : high while a request is being serviced
//   isr        : one-hot in-service vector
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     irq_in,
  input  logic [N-1:0]     mask,
  input  logic             edge_mode,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_id,
  input  logic             eoi,
  output logic [N-1:0]     req,
  output logic             irq,
  output logic             in_service,
  output logic [N-1:0]     isr
);

  logic [N-1:0] s;
  logic [N-1:0] prev_q, prev_d;
  logic [N-1:0] rise;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] isr_q, isr_d;
  logic [N-1:0] ack_onehot;
  logic         ack_ok;
  state_e       state_q, state_d;

  for (genvar i = 0; i < N; i++) begin : g_sync
    sync_ff #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (irq_in[i]),
      .q    (s[i])
    );
  end

  // prev resets to 0, so a line already high at reset release is seen
  // as one rising edge.
  always_comb begin
    prev_d = s;
    rise   = s & ~prev_q;
  end

  assign req = pending_q & mask;

  // An ack only counts while the request is being presented and the
  // acknowledged bit is actually requesting; req here is the registered
  // value, so a same-cycle drop of req does not disqualify the ack.
  always_comb begin
    ack_onehot         = '0;
    ack_onehot[ack_id] = 1'b1;
    ack_ok             = (state_q == REQ) && ack && req[ack_id];
  end

  // Edge mode: clear on a qualified ack, then OR in new edges so a
  // coinciding edge is never lost. Level mode simply follows the line.
  always_comb begin
    pending_d = pending_q;
    if (edge_mode) begin
      if (ack_ok) begin
        pending_d = pending_d & ~ack_onehot;
      end
      pending_d = pending_d | rise;
    end else begin
      pending_d = s;
    end
  end

  // Handshake FSM: requests accumulate in pending during SVC; a stray
  // ack outside REQ or a stray eoi outside SVC falls through unchanged.
  always_comb begin
    state_d = state_q;
    isr_d   = isr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_ok) begin
          state_d = SVC;
          isr_d   = ack_onehot;
        end else if (req == '0) begin
          state_d = IDLE;
        end
      end
      SVC: begin
        if (eoi) begin
          state_d = IDLE;
          isr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        isr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      isr_q     <= '0;
      state_q   <= IDLE;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      isr_q     <= isr_d;
      state_q   <= state_d;
    end
  end

  assign irq        = (state_q == REQ);
  assign in_service = (state_q == SVC);
  assign isr        = isr_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Testbench for irq_pending_ctrl: directed scenarios with literal expected
// values, then randomized traffic checked against a behavioural model.
module tb_irq_pending_ctrl;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       edge_mode;
  logic       ack;
  logic [2:0] ack_id;
  logic       eoi;
  logic [7:0] req;
  logic       irq;
  logic       in_service;
  logic [7:0] isr;

  int checks   = 0;
  int failures = 0;

  irq_pending_ctrl #(
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask      (mask),
    .edge_mode (edge_mode),
    .ack       (ack),
    .ack_id    (ack_id),
    .eoi       (eoi),
    .req       (req),
    .irq       (irq),
    .in_service(in_service),
    .isr       (isr)
  );

  always #5 clk = ~clk;

  // Behavioural model: the synchronised view of each line is just irq_in
  // as seen SYNC_STAGES edges ago; the handshake is tracked as "waiting
  // for ack" plus the index being served (-1 when none).
  logic [7:0] hist_m [SYNC_STAGES];
  logic [7:0] last_seen_m;
  logic [7:0] latched_m;
  bit         waiting_m;
  int         served_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) hist_m[i] = 8'h00;
      last_seen_m = 8'h00;
      latched_m   = 8'h00;
      waiting_m   = 0;
      served_m    = -1;
    end else begin
      logic [7:0] seen;
      logic [7:0] visible;
      bit         taken;
      seen    = hist_m[SYNC_STAGES-1];
      visible = latched_m & mask;
      taken   = waiting_m && ack && visible[ack_id];
      if (edge_mode) begin
        if (taken) latched_m[ack_id] = 1'b0;
        latched_m = latched_m | (seen & ~last_seen_m);
      end else begin
        latched_m = seen;
      end
      if (waiting_m) begin
        if (taken) begin
          waiting_m = 0;
          served_m  = int'(ack_id);
        end else if (visible == 8'h00) begin
          waiting_m = 0;
        end
      end else if (served_m >= 0) begin
        if (eoi) served_m = -1;
      end else if (visible != 8'h00) begin
        waiting_m = 1;
      end
      for (int i = SYNC_STAGES - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
      hist_m[0]   = irq_in;
      last_seen_m = seen;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    irq_in    = 8'h00;
    mask      = 8'hFF;
    edge_mode = 1'b1;
    ack       = 1'b0;
    ack_id    = 3'd0;
    eoi       = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    irq_in    = 8'hFF;
    mask      = 8'hFF;
    edge_mode = 1'b1;
    ack       = 1'b0;
    ack_id    = 3'd0;
    eoi       = 1'b0;
    #1;
    checks++; if (req !== 8'h00) begin failures++; $display("[TB] FAIL reset_req: got %h expected 00", req); end
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (isr !== 8'h00) begin failures++; $display("[TB] FAIL reset_isr: got %h expected 00", isr); end
    checks++; if (in_service !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_service: got %b expected 0", in_service); end
    step(3);
    checks++; if (req !== 8'h00) begin failures++; $display("[TB] FAIL reset_held_req: got %h expected 00", req); end
    irq_in = 8'h00;
    rst_n  = 1'b1;
    step(4);
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_irq: got %b expected 0", irq); end
  endtask

  task automatic test_edge_basic();
    do_reset();
    irq_in = 8'h20;
    step(2);
    checks++; if (req !== 8'h00) begin failures++; $display("[TB] FAIL edge_req_e2: got %h expected 00", req); end
    step(1);
    checks++; if (req !== 8'h20) begin failures++; $display("[TB] FAIL edge_req_e3: got %h expected 20", req); end
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL edge_irq_e3: got %b expected 0", irq); end
    step(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL edge_irq_e4: got %b expected 1", irq); end
    ack = 1'b1; ack_id = 3'd5;
    step(1);
    ack = 1'b0;
    checks++; if (isr !== 8'h20) begin failures++; $display("[TB] FAIL edge_ack_isr: got %h expected 20", isr); end
    checks++; if (in_service !== 1'b1) begin failures++; $display("[TB] FAIL edge_ack_in_service: got %b expected 1", in_service); end
    checks++; if (req !== 8'h00) begin failures++; $display("[TB] FAIL edge_ack_req: got %h expected 00", req); end
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL edge_ack_irq: got %b expected 0", irq); end
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    checks++; if (isr !== 8'h00) begin failures++; $display("[TB] FAIL edge_eoi_isr: got %h expected 00", isr); end
    checks++; if (in_service !== 1'b0) begin failures++; $display("[TB] FAIL edge_eoi_in_service: got %b expected 0", in_service); end
    step(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL edge_eoi_irq_quiet: got %b expected 0", irq); end
  endtask

  task automatic test_mask();
    do_reset();
    mask   = 8'h7F;
    irq_in = 8'h84;
    step(1);
    irq_in = 8'h00;
    step(3);
    checks++; if (req !== 8'h04) begin failures++; $display("[TB] FAIL mask_req: got %h expected 04", req); end
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL mask_irq: got %b expected 1", irq); end
    ack = 1'b1; ack_id = 3'd2;
    step(1);
    ack = 1'b0;
    checks++; if (isr !== 8'h04) begin failures++; $display("[TB] FAIL mask_isr: got %h expected 04", isr); end
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    checks++; if (req !== 8'h00) begin failures++; $display("[TB] FAIL mask_req_hidden: got %h expected 00", req); end
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL mask_irq_hidden: got %b expected 0", irq); end
    mask = 8'hFF;
    #1;
    checks++; if (req !== 8'h80) begin failures++; $display("[TB] FAIL mask_unmask_req: got %h expected 80", req); end
    step(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL mask_unmask_irq: got %b expected 1", irq); end
  endtask

  task automatic test_level();
    do_reset();
    edge_mode = 1'b0;
    irq_in    = 8'h08;
    step(3);
    checks++; if (req !== 8'h08) begin failures++; $display("[TB] FAIL level_req: got %h expected 08", req); end
    step(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL level_irq: got %b expected 1", irq); end
    ack = 1'b1; ack_id = 3'd3;
    step(1);
    ack = 1'b0;
    checks++; if (isr !== 8'h08) begin failures++; $display("[TB] FAIL level_isr: got %h expected 08", isr); end
    checks++; if (req !== 8'h08) begin failures++; $display("[TB] FAIL level_req_kept: got %h expected 08", req); end
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL level_eoi_irq: got %b expected 0", irq); end
    step(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL level_reassert_irq: got %b expected 1", irq); end
    irq_in = 8'h00;
    step(2);
    checks++; if (req !== 8'h08) begin failures++; $display("[TB] FAIL level_drop_req_early: got %h expected 08", req); end
    step(1);
    checks++; if (req !== 8'h00) begin failures++; $display("[TB] FAIL level_drop_req: got %h expected 00", req); end
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL level_drop_irq_early: got %b expected 1", irq); end
    step(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL level_drop_irq: got %b expected 0", irq); end
    checks++; if (in_service !== 1'b0) begin failures++; $display("[TB] FAIL level_drop_in_service: got %b expected 0", in_service); end
  endtask

  task automatic test_bogus();
    do_reset();
    irq_in = 8'h10;
    step(4);
    checks++; if (req !== 8'h10) begin failures++; $display("[TB] FAIL bogus_req: got %h expected 10", req); end
    ack = 1'b1; ack_id = 3'd1;
    step(1);
    ack = 1'b0;
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL bogus_ack_irq: got %b expected 1", irq); end
    checks++; if (isr !== 8'h00) begin failures++; $display("[TB] FAIL bogus_ack_isr: got %h expected 00", isr); end
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL bogus_eoi_irq: got %b expected 1", irq); end
    checks++; if (in_service !== 1'b0) begin failures++; $display("[TB] FAIL bogus_eoi_in_service: got %b expected 0", in_service); end
    ack = 1'b1; ack_id = 3'd4; irq_in = 8'h12;
    step(1);
    ack = 1'b0;
    checks++; if (isr !== 8'h10) begin failures++; $display("[TB] FAIL bogus_good_ack_isr: got %h expected 10", isr); end
    step(2);
    checks++; if (req !== 8'h02) begin failures++; $display("[TB] FAIL bogus_svc_accum_req: got %h expected 02", req); end
    ack = 1'b1; ack_id = 3'd1;
    step(1);
    ack = 1'b0;
    checks++; if (isr !== 8'h10) begin failures++; $display("[TB] FAIL bogus_svc_ack_isr: got %h expected 10", isr); end
    checks++; if (in_service !== 1'b1) begin failures++; $display("[TB] FAIL bogus_svc_ack_in_service: got %b expected 1", in_service); end
    ack = 1'b1; ack_id = 3'd1; eoi = 1'b1;
    step(1);
    ack = 1'b0; eoi = 1'b0;
    checks++; if (isr !== 8'h00) begin failures++; $display("[TB] FAIL bogus_ack_eoi_isr: got %h expected 00", isr); end
    checks++; if (in_service !== 1'b0) begin failures++; $display("[TB] FAIL bogus_ack_eoi_in_service: got %b expected 0", in_service); end
    step(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL bogus_after_eoi_irq: got %b expected 1", irq); end
  endtask

  task automatic test_set_clear_collision();
    do_reset();
    irq_in = 8'h10;
    step(4);
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL collide_irq: got %b expected 1", irq); end
    irq_in = 8'h00;
    step(1);
    irq_in = 8'h10;
    step(2);
    ack = 1'b1; ack_id = 3'd4;
    step(1);
    ack = 1'b0;
    checks++; if (isr !== 8'h10) begin failures++; $display("[TB] FAIL collide_isr: got %h expected 10", isr); end
    checks++; if (req !== 8'h10) begin failures++; $display("[TB] FAIL collide_req: got %h expected 10", req); end
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    step(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL collide_reassert_irq: got %b expected 1", irq); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    irq_in = 8'h0B;
    step(4);
    checks++; if (req !== 8'h0B) begin failures++; $display("[TB] FAIL rstmid_req: got %h expected 0b", req); end
    ack = 1'b1; ack_id = 3'd0;
    step(1);
    ack = 1'b0;
    checks++; if (req !== 8'h0A) begin failures++; $display("[TB] FAIL rstmid_svc_req: got %h expected 0a", req); end
    checks++; if (isr !== 8'h01) begin failures++; $display("[TB] FAIL rstmid_svc_isr: got %h expected 01", isr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (req !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_req_async: got %h expected 00", req); end
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_irq_async: got %b expected 0", irq); end
    checks++; if (isr !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_isr_async: got %h expected 00", isr); end
    checks++; if (in_service !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_in_service_async: got %b expected 0", in_service); end
    irq_in = 8'h01;
    step(1);
    rst_n = 1'b1;
    step(3);
    checks++; if (req !== 8'h01) begin failures++; $display("[TB] FAIL rstmid_redetect_req: got %h expected 01", req); end
    checks++; if (irq !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_redetect_irq_e3: got %b expected 0", irq); end
    step(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_redetect_irq_e4: got %b expected 1", irq); end
  endtask

  task automatic test_random();
    logic [7:0] exp_req;
    logic [7:0] exp_isr;
    logic [7:0] one;
    int         k;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      step(1);
      exp_req = latched_m & mask;
      one     = 8'h01;
      exp_isr = (served_m >= 0) ? (one << served_m) : 8'h00;
      checks++; if (req !== exp_req) begin failures++; $display("[TB] FAIL rand_req cycle %0d: got %h expected %h", cyc, req, exp_req); end
      checks++; if (irq !== waiting_m) begin failures++; $display("[TB] FAIL rand_irq cycle %0d: got %b expected %b", cyc, irq, waiting_m); end
      checks++; if (isr !== exp_isr) begin failures++; $display("[TB] FAIL rand_isr cycle %0d: got %h expected %h", cyc, isr, exp_isr); end
      checks++; if (in_service !== (served_m >= 0)) begin failures++; $display("[TB] FAIL rand_in_service cycle %0d: got %b expected %b", cyc, in_service, served_m >= 0); end
      irq_in = irq_in ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom | $urandom);
      if ($urandom_range(0, 63) == 0) edge_mode = ~edge_mode;
      ack = ($urandom_range(0, 2) == 0);
      if (exp_req != 8'h00 && $urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, 7);
        while (!exp_req[k]) k = (k + 1) % 8;
        ack_id = 3'(k);
      end else begin
        ack_id = 3'($urandom_range(0, 7));
      end
      eoi = ($urandom_range(0, 3) == 0);
    end
    ack = 1'b0;
    eoi = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_edge_basic();
    test_mask();
    test_level();
    test_bogus();
    test_set_clear_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
